// File: rtl/hilo_ctrl_pkg.sv
// Shared types for the HI/LO multiply-divide controller.
package hilo_ctrl_pkg;

   typedef logic [31:0] uint32_t;
   typedef logic [63:0] uint64_t;

   typedef enum logic [3:0] {
      OP_MULT  = 4'd0,
      OP_MULTU = 4'd1,
      OP_DIV   = 4'd2,
      OP_DIVU  = 4'd3,
      OP_MADD  = 4'd4,
      OP_MADDU = 4'd5,
      OP_MSUB  = 4'd6,
      OP_MSUBU = 4'd7,
      OP_MTHI  = 4'd8,
      OP_MTLO  = 4'd9
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } hilo_state_t;

   // Ops that go through the multi-cycle multiplier.
   function automatic logic op_is_mul(input muldiv_op_t o);
      case (o)
         OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic op_is_div(input muldiv_op_t o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   // Two's-complement interpretation of the operands.
   function automatic logic op_is_signed(input muldiv_op_t o);
      case (o)
         OP_MULT, OP_DIV, OP_MADD, OP_MSUB: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hilo_ctrl_div.sv
// Unsigned 32/32 radix-2 restoring divider, one quotient bit per cycle.
// start loads the operands; 32 cycles later done pulses with the result
// presented combinationally from the final iteration.
module div_iter
   import hilo_ctrl_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    start,
   input  logic    abort,
   input  uint32_t dividend,
   input  uint32_t divisor,
   output logic    done,
   output uint32_t quotient,
   output uint32_t remainder
);

   uint32_t    rem_q, quo_q, dvs_q;
   logic [4:0] cnt_q;
   logic       busy_q;

   logic [32:0] trial, diff;
   logic        qbit;
   uint32_t     rem_d, quo_d;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      trial = {rem_q, quo_q[31]};
      diff  = trial - {1'b0, dvs_q};
      qbit  = ~diff[32];
      rem_d = qbit ? diff[31:0] : trial[31:0];
      quo_d = {quo_q[30:0], qbit};
   end

   assign done      = busy_q && (cnt_q == 5'd31);
   assign quotient  = quo_d;
   assign remainder = rem_d;

   // Iteration registers; abort drops the divide without a result.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (abort) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else if (start) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q + 5'd1;
         if (cnt_q == 5'd31) busy_q <= 1'b0;
      end
   end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: MTHI/MTLO, multi-cycle multiply(-accumulate) and
// iterative divide, with forwarding of a just-issued HILO write.
module hilo_ctrl
   import hilo_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       op_valid,
   input  muldiv_op_t op,
   input  uint32_t    rs,
   input  uint32_t    rt,
   input  uint64_t    hilo_rd,
   output logic       busy,
   output logic       hilo_we,
   output uint64_t    hilo_wd
);

   localparam logic [3:0] MC = MUL_CYCLES[3:0];

   hilo_state_t state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   uint64_t     wd_q, wd_d;
   muldiv_op_t  op_q;
   uint32_t     rs_q, rt_q;

   uint64_t eff, prod, mul_res, div_res;
   logic    accept, sg_in, sg_q;
   uint32_t dvd_abs, dvs_abs, uq, ur;
   logic    div_done;

   assign busy    = (state_q != ST_IDLE);
   assign hilo_we = we_q;
   assign hilo_wd = wd_q;
   assign eff     = we_q ? wd_q : hilo_rd;
   assign accept  = (state_q == ST_IDLE) && op_valid && !flush;
   assign sg_in   = op_is_signed(op);
   assign sg_q    = op_is_signed(op_q);
   assign dvd_abs = (sg_in && rs[31]) ? -rs : rs;
   assign dvs_abs = (sg_in && rt[31]) ? -rt : rt;

   div_iter u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (accept && op_is_div(op)),
      .abort     (flush && (state_q == ST_DIV)),
      .dividend  (dvd_abs),
      .divisor   (dvs_abs),
      .done      (div_done),
      .quotient  (uq),
      .remainder (ur)
   );

   // Multiply result: low 64 bits of the sign/zero-extended product, then accumulate.
   always_comb begin
      prod = {{32{sg_q & rs_q[31]}}, rs_q} * {{32{sg_q & rt_q[31]}}, rt_q};
      case (op_q)
         OP_MADD, OP_MADDU: mul_res = eff + prod;
         OP_MSUB, OP_MSUBU: mul_res = eff - prod;
         default:           mul_res = prod;
      endcase
   end

   // Divide result: special cases first, then sign fix-up of the magnitudes.
   always_comb begin
      if (rt_q == 32'd0)
         div_res = {rs_q, 32'hFFFF_FFFF};
      else if (sg_q && rs_q == 32'h8000_0000 && rt_q == 32'hFFFF_FFFF)
         div_res = {32'd0, 32'h8000_0000};
      else
         div_res = {(sg_q && rs_q[31]) ? -ur : ur,
                    (sg_q && (rs_q[31] ^ rt_q[31])) ? -uq : uq};
   end

   // Next state, cycle counter and HILO write request.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      wd_d    = wd_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (op == OP_MTHI) begin
                  we_d = 1'b1;
                  wd_d = {rs, eff[31:0]};
               end else if (op == OP_MTLO) begin
                  we_d = 1'b1;
                  wd_d = {eff[63:32], rs};
               end else if (op_is_div(op)) begin
                  state_d = ST_DIV;
               end else if (op_is_mul(op)) begin
                  state_d = ST_MUL;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == MC) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               we_d    = 1'b1;
               wd_d    = mul_res;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (div_done) begin
               state_d = ST_IDLE;
               we_d    = 1'b1;
               wd_d    = div_res;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state; reset overrides everything, including flush and new ops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         wd_q    <= wd_d;
      end
   end

   // Capture the accepted instruction for the multi-cycle ops.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= OP_MULT;
         rs_q <= '0;
         rt_q <= '0;
      end else if (accept) begin
         op_q <= op;
         rs_q <= rs;
         rt_q <= rt;
      end
   end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed corner cases plus random ops
// checked against an arithmetic reference of the instruction semantics.
module tb_hilo_ctrl;
   import hilo_ctrl_pkg::*;

   localparam int MC = 2;

   logic       clk = 1'b0;
   logic       rst, flush, op_valid;
   muldiv_op_t op;
   uint32_t    rs, rt;
   uint64_t    hilo_rd;
   logic       busy, hilo_we;
   uint64_t    hilo_wd;

   int n_cmp = 0;
   int n_err = 0;
   uint64_t mhilo;   // architectural HILO as the reference expects it

   always #5 clk = ~clk;

   // Architectural HI/LO register fed by the DUT's write port.
   always @(posedge clk) begin
      if (rst) hilo_rd <= '0;
      else if (hilo_we) hilo_rd <= hilo_wd;
   end

   hilo_ctrl #(.MUL_CYCLES(MC)) dut (
      .clk(clk), .rst(rst), .flush(flush), .op_valid(op_valid), .op(op),
      .rs(rs), .rt(rt), .hilo_rd(hilo_rd), .busy(busy),
      .hilo_we(hilo_we), .hilo_wd(hilo_wd)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference semantics of each instruction.
   function automatic uint64_t ref_res(input muldiv_op_t o, input uint32_t a, input uint32_t b,
                                       input uint64_t h);
      longint sa, sb, sq, sr;
      longint unsigned ua, ub;
      uint32_t q32, r32;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         OP_MULT:  return uint64_t'(sa * sb);
         OP_MULTU: return ua * ub;
         OP_MADD:  return h + uint64_t'(sa * sb);
         OP_MADDU: return h + ua * ub;
         OP_MSUB:  return h - uint64_t'(sa * sb);
         OP_MSUBU: return h - ua * ub;
         OP_MTHI:  return {a, h[31:0]};
         OP_MTLO:  return {h[63:32], a};
         OP_DIVU: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q32 = a / b;
            r32 = a % b;
            return {r32, q32};
         end
         default: begin   // OP_DIV
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sq = sa / sb;
            sr = sa % sb;
            q32 = sq[31:0];
            r32 = sr[31:0];
            return {r32, q32};
         end
      endcase
   endfunction

   function automatic int ref_lat(input muldiv_op_t o);
      if (o == OP_MTHI || o == OP_MTLO) return 1;
      if (o == OP_DIV || o == OP_DIVU) return 33;
      return MC + 1;
   endfunction

   function automatic uint32_t pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one op and check the busy window, write cycle, value and hold.
   // noise=1 throws random op_valid pulses at the DUT while it is busy.
   task automatic run_op(input muldiv_op_t o, input uint32_t a, input uint32_t b, input bit noise);
      uint64_t exp;
      int lat;
      exp = ref_res(o, a, b, mhilo);
      lat = ref_lat(o);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; rs = a; rt = b;
      @(negedge clk);
      chk("busy_at_issue", busy, 0);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         if (k < lat && noise) begin
            op_valid = 1'($urandom_range(0, 1));
            op = muldiv_op_t'(4'($urandom_range(0, 9)));
            rs = 32'($urandom); rt = 32'($urandom);
         end else begin
            op_valid = 1'b0;
         end
         @(negedge clk);
         if (k < lat) begin
            chk($sformatf("busy_%s_k%0d", o.name(), k), busy, 1);
            chk($sformatf("we_early_%s_k%0d", o.name(), k), hilo_we, 0);
         end else begin
            chk($sformatf("we_%s", o.name()), hilo_we, 1);
            chk($sformatf("wd_%s_%h_%h", o.name(), a, b), hilo_wd, exp);
            chk($sformatf("busy_wr_%s", o.name()), busy, 0);
         end
      end
      mhilo = exp;
      op_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("we_pulse", hilo_we, 0);
      chk("wd_hold", hilo_wd, exp);
   endtask

   // Issue an op and flush it fk cycles later; no write may appear.
   task automatic flush_op(input muldiv_op_t o, input uint32_t a, input uint32_t b, input int fk);
      @(posedge clk); #1;
      op_valid = 1'b1; op = o; rs = a; rt = b;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         op_valid = 1'b0;
         flush = (k == fk);
         @(negedge clk);
         chk($sformatf("flush_busy_k%0d", k), busy, (k <= fk) ? 1 : 0);
         chk($sformatf("flush_we_k%0d", k), hilo_we, 0);
      end
      #1 flush = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op = OP_MULT; rs = '0; rt = '0;
      mhilo = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_we", hilo_we, 0);
      chk("rst_wd", hilo_wd, 0);
      // reset wins over a coincident op
      op_valid = 1'b1; op = OP_MTHI; rs = 32'hDEAD;
      @(negedge clk);
      chk("rst_prio_we", hilo_we, 0);
      chk("rst_prio_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b0; op_valid = 1'b0;

      // MTHI then MTLO back to back: second write forwards the first
      @(posedge clk); #1;
      op_valid = 1'b1; op = OP_MTHI; rs = 32'h1234; rt = '0;
      @(posedge clk); #1;
      op = OP_MTLO; rs = 32'h5678;
      @(negedge clk);
      chk("mthi_we", hilo_we, 1);
      chk("mthi_wd", hilo_wd, {32'h1234, 32'h0});
      @(posedge clk); #1;
      op_valid = 1'b0;
      @(negedge clk);
      chk("mtlo_we", hilo_we, 1);
      chk("mtlo_wd", hilo_wd, {32'h1234, 32'h5678});
      mhilo = {32'h1234, 32'h5678};
      @(negedge clk);
      chk("mtlo_pulse", hilo_we, 0);

      run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
      chk("mult_neg", hilo_wd, 64'hFFFFFFFF_FFFFFFEB);

      run_op(OP_MTHI, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
      chk("maddu_wrap", hilo_wd, 64'd0);

      run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      chk("div_neg", hilo_wd, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_op(OP_DIVU, 32'd9, 32'd0, 1'b0);
      chk("divu_zero", hilo_wd, {32'd9, 32'hFFFF_FFFF});
      run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf", hilo_wd, {32'd0, 32'h8000_0000});

      // flushed divide, then a clean multiply
      flush_op(OP_DIV, 32'd100, 32'd7, 10);
      run_op(OP_MULTU, 32'd2, 32'd3, 1'b0);
      chk("multu_after_flush", hilo_wd, 64'd6);
      flush_op(OP_MADD, 32'd5, 32'd5, MC);

      // op coincident with flush in IDLE is dropped
      @(posedge clk); #1;
      op_valid = 1'b1; op = OP_MTHI; rs = 32'hAAAA; flush = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush_drop_we", hilo_we, 0);
      chk("flush_drop_busy", busy, 0);

      // random ops with busy-time noise
      for (int i = 0; i < 60; i++)
         run_op(muldiv_op_t'(4'($urandom_range(0, 9))), pick(), pick(), 1'b1);

      // reset while a multiply is in flight discards it
      @(posedge clk); #1;
      op_valid = 1'b1; op = OP_MULTU; rs = 32'd11; rt = 32'd13;
      @(posedge clk); #1;
      op_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mhilo = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("rst_flight_we_%0d", k), hilo_we, 0);
         chk($sformatf("rst_flight_busy_%0d", k), busy, 0);
      end
      run_op(OP_MADD, 32'hFFFF_FFFF, 32'd4, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 2, meaning the number of cycles spent in state MUL (legal range 1..8).
REQ-002 The block SHALL have port clk  in  1  clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst  in  1  reset; rst is synchronous, active-high.
REQ-004 The block SHALL have port flush  in  1  abort of the in-flight op (exception or branch kill).
REQ-005 The block SHALL have port op_valid  in  1  one-cycle pulse per instruction, legal only while busy=0.
REQ-006 The block SHALL have port op  in  4  muldiv_op_t: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO.
REQ-007 The block SHALL have ports rs  in  32 and rt  in  32, the operands.
REQ-008 The block SHALL have port hilo_rd  in  64  current HILO value, {hi, lo}.
REQ-009 The block SHALL have port busy  out  1  stall request to the pipeline.
REQ-010 The block SHALL have ports hilo_we  out  1 and hilo_wd  out  64, the HILO write request.

Function
REQ-011 State machine SHALL be: IDLE, MUL, DIV; busy SHALL equal (state != IDLE).
REQ-012 Ops SHALL be accepted only when state=IDLE, op_valid=1 and flush=0; op_valid while busy SHALL be ignored.
REQ-013 Effective HILO SHALL be hilo_wd when hilo_we=1, else hilo_rd; every op that reads HILO SHALL use it (back-to-back forwarding).
REQ-014 MTHI accepted in cycle T SHALL drive hilo_we=1 in T+1 with wd={rs, eff_lo}; MTLO SHALL write {eff_hi, rs}; the state SHALL stay IDLE.
REQ-015 MULT, MULTU, MADD, MADDU, MSUB and MSUBU accepted in T SHALL occupy state MUL in T+1..T+MUL_CYCLES and write in T+MUL_CYCLES+1 with busy=0 in that cycle.
REQ-016 MULT and MULTU SHALL write the 64-bit signed or unsigned product of rs*rt.
REQ-017 MADD and MSUB SHALL write eff_hilo +/- product, with eff_hilo sampled in the write cycle, modulo 2^64.
REQ-018 DIV and DIVU accepted in T SHALL occupy state DIV in T+1..T+32 and write in T+33 with wd={remainder, quotient}.
REQ-019 Signed divide: quotient sign SHALL be rs[31]^rt[31]; remainder sign SHALL be that of rs.
REQ-020 Divide by zero SHALL give quotient 32'hFFFFFFFF and remainder rs; no exception is raised.
REQ-021 Signed -2^31 / -1 SHALL give quotient 32'h80000000 and remainder 0.
REQ-022 flush in MUL or DIV SHALL return the state to IDLE next cycle and suppress that op's write.
REQ-023 A hilo_we already high in the flush cycle SHALL complete; op_valid coincident with flush SHALL be dropped.
REQ-024 hilo_we SHALL be a one-cycle pulse; hilo_wd SHALL hold its last value when hilo_we=0.

Reset
REQ-025 While rst=1: state=IDLE, busy=0, hilo_we=0, hilo_wd=0, cycle counter=0, divider idle.
REQ-026 rst SHALL take priority over flush and op_valid; an op in flight at reset SHALL be discarded without a write.

Structure
REQ-027 muldiv_op_t and the uint32_t/uint64_t typedefs SHALL live in the shared regs package; MUL_CYCLES stays a module parameter.
REQ-028 One sub-module, div_iter, SHALL be instantiated: unsigned 32/32 radix-2 restoring divider with ports start, abort, done, quotient and remainder, taking 32 cycles.
REQ-029 Sign fix-up and the divide-by-zero and overflow cases SHALL be handled in hilo_ctrl; the multiplier SHALL be inline and may be retimed across the MUL_CYCLES stages.

Verification
REQ-030 Scenario: MTHI rs=32'h1234 then MTLO rs=32'h5678 in consecutive cycles, with hilo_rd=0 -> second write is {32'h1234, 32'h5678}.
REQ-031 Scenario: MULT rs=-3, rt=7, MUL_CYCLES=2, accepted at T -> busy in T+1..T+2; hilo_we at T+3 with wd=64'hFFFFFFFF_FFFFFFEB.
REQ-032 Scenario: MADDU with HILO=64'hFFFFFFFF_FFFFFFFF, rs=1, rt=1 -> wd=0 (wrap).
REQ-033 Scenario: DIV rs=-7, rt=2 -> hilo_we at T+33 with wd={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-034 Scenario: DIVU rt=0, rs=9 -> wd={9, 32'hFFFFFFFF}; then DIV 32'h80000000 / -1 -> wd={0, 32'h80000000}.
REQ-035 Scenario: DIV accepted, flush at T+10 -> busy=0 at T+11, no hilo_we; a following MULTU 2*3 -> wd=6.
